// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks: status codes, grid geometry and
// the renderer state encoding.
package snake_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_SNAKE = 2'd1;
  localparam logic [1:0] ST_FOOD  = 2'd2;
  localparam logic [1:0] ST_WALL  = 2'd3;

  localparam int GRID_X  = 160;
  localparam int GRID_Y  = 120;
  localparam int ADDR_XW = 8;
  localparam int ADDR_YW = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2,
    S_FIN   = 2'd3
  } render_state_e;

endpackage

// File: rtl/board_renderer_raster_counter.sv
// Raster-order x/y address counter for the status RAM scan; x runs fastest and
// the whole counter wraps back to (0,0) after the last cell.
module raster_counter
  import snake_pkg::*;
#(
  parameter int X_CELLS = GRID_X,
  parameter int Y_CELLS = GRID_Y
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic               clr_i,
  output logic [ADDR_XW-1:0] x_o,
  output logic [ADDR_YW-1:0] y_o,
  output logic               last_o
);

  localparam logic [ADDR_XW-1:0] X_LAST = ADDR_XW'(X_CELLS - 1);
  localparam logic [ADDR_YW-1:0] Y_LAST = ADDR_YW'(Y_CELLS - 1);

  logic [ADDR_XW-1:0] x_q, x_d;
  logic [ADDR_YW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + ADDR_YW'(1);
      end else begin
        x_d = x_q + ADDR_XW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/board_renderer.sv
// Scans the cell-status RAM in raster order and issues one VGA plot per cell.
//   state | meaning
//   IDLE  | waiting for go; read address parked at (0,0)
//   SCAN  | walking the RAM; hold stalls the walk for a cycle
//   FLUSH | final cell's plot presented
//   FIN   | done pulse, then back to IDLE
module board_renderer
  import snake_pkg::*;
#(
  parameter int         X_CELLS   = GRID_X,
  parameter int         Y_CELLS   = GRID_Y,
  parameter logic [2:0] COL_EMPTY = 3'b000,
  parameter logic [2:0] COL_SNAKE = 3'b010,
  parameter logic [2:0] COL_FOOD  = 3'b100,
  parameter logic [2:0] COL_WALL  = 3'b111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               hold,
  output logic [ADDR_XW-1:0] rd_x,
  output logic [ADDR_YW-1:0] rd_y,
  input  logic [1:0]         status_in,
  output logic [ADDR_XW-1:0] x,
  output logic [ADDR_YW-1:0] y,
  output logic [2:0]         colour,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  render_state_e      state_q, state_d;
  logic               valid_q, valid_d;
  logic [ADDR_XW-1:0] x_q, x_d;
  logic [ADDR_YW-1:0] y_q, y_d;
  logic               cnt_en, cnt_clr, cnt_last;

  raster_counter #(
    .X_CELLS(X_CELLS),
    .Y_CELLS(Y_CELLS)
  ) u_raster (
    .clk   (clk),
    .reset (reset),
    .en_i  (cnt_en),
    .clr_i (cnt_clr),
    .x_o   (rd_x),
    .y_o   (rd_y),
    .last_o(cnt_last)
  );

  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (go) state_d = S_SCAN;
      end
      S_SCAN: begin
        // A held edge re-presents the same address, so the RAM re-reads it
        if (!hold) begin
          cnt_en  = 1'b1;
          valid_d = 1'b1;
          x_d     = rd_x;
          y_d     = rd_y;
          if (cnt_last) state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Unregistered so the colour lines up with the RAM data that arrives with x/y/plot
  always_comb begin
    colour = COL_EMPTY;
    case (status_in)
      ST_EMPTY: colour = COL_EMPTY;
      ST_SNAKE: colour = COL_SNAKE;
      ST_FOOD:  colour = COL_FOOD;
      ST_WALL:  colour = COL_WALL;
      default:  colour = COL_EMPTY;
    endcase
  end

  assign x    = x_q;
  assign y    = y_q;
  assign plot = valid_q;
  assign busy = (state_q == S_SCAN) || (state_q == S_FLUSH);
  assign done = (state_q == S_FIN);

endmodule
